muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit; parametrised successor to the single-cycle integer ALU.
- Sits beside the ALU in execute and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus the W forms when XLEN=64.
- Valid/ready on both sides; one operation in flight; radix-2 shift-add multiply and restoring divide.

Parameters:
- XLEN, 64, operand/result width (32 or 64); at 32, W ops are illegal and treated as non-W.
- EARLY_SPECIAL, 1, 1 = divide-by-zero and signed overflow complete without iterating.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill the in-flight op; no result produced
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept (high only in IDLE)
- op_i  in  md_op_t  operation select
- op_a_i  in  XLEN  rs1 value
- op_b_i  in  XLEN  rs2 value
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  XLEN  result, stable while valid_o && !ready_i

Behaviour:
- Reset values: state IDLE, ready_o=1, valid_o=0, result_o=0, all datapath registers 0.
- FSM states:
  - IDLE: accept on valid_i && ready_o. Go to DONE if the op is special and EARLY_SPECIAL=1, otherwise go to BUSY with cnt = N-1.
  - BUSY: one iteration per cycle. When cnt==0, latch the sign-fixed result and go to DONE.
  - DONE: valid_o=1. On ready_i, return to IDLE; no same-cycle accept.
- Iteration count N: XLEN for full ops, 32 for W ops.
- Latency (accept edge to first valid_o cycle): N+1 edges, or 1 edge for a special case.
- Signed ops: operands are converted to magnitudes at accept, and the recorded sign is applied at the end.
  - MULH: signed × signed. MULHSU: rs1 signed, rs2 unsigned.
  - Quotient sign = sa^sb. Remainder sign = sa.
- Multiply: 2·XLEN product register. MUL returns the low XLEN bits; MULH* return the high XLEN bits after sign correction of the full 2·XLEN product.
- W ops: use low 32 bits of the operands; the 32-bit result is sign-extended to 64 (DIVUW/REMUW results are also sign-extended).
- Divide by zero: quotient = all ones; remainder = dividend (width-adjusted for W).
- Signed overflow (most-negative ÷ −1, per width): quotient = dividend; remainder = 0.
- flush_i:
  - In BUSY or DONE: go to IDLE next edge; valid_o drops. flush_i has priority over ready_i.
  - In IDLE: a simultaneous valid_i is not accepted.
- Async reset mid-operation: state discarded, outputs return to reset values.
- Illegal op_i encoding: result 0 with latency 1.

Optional Feature:
- MULDIV_FAST_MUL_EN: multiply ops use a single-cycle combinational XLEN×XLEN multiplier; result latency is 1 edge.
  - Divide path is unchanged.
- Without the macro: multiply is iterative with N+1 latency as above.

Decomposition:
- riscv_pkg gets:
  - md_op_t enum: MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW.
  - md_state_t enum: IDLE/BUSY/DONE.
  - Helper function is_word_op().
- One natural sub-module, muldiv_iter_core: the per-cycle shift-add / restore-subtract datapath step. The FSM and sign fix-up stay in muldiv_unit.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB; valid_o first high 65 edges after accept (1 edge with MULDIV_FAST_MUL_EN).
- MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> 1; MULH a=-1, b=-1 -> 0; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -20/3 -> 0xFFFF_FFFF_FFFF_FFFA (-6); REM -20/3 -> -2; DIVW a=0x1_0000_0010, b=4 -> 4, valid after 33 edges.
- DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF and REM 5/0 -> 5, latency 1. DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000 and REM -> 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o and result_o stable; ready_o=0 throughout; ready_o=1 the cycle after the handshake.
- flush_i at BUSY cycle 20 -> IDLE next edge, no valid_o; next DIVU 100/7 -> 14 after full latency.
- rst_ni low mid-BUSY -> valid_o=0 and ready_o=1 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared execute-stage types: multiply/divide op encodings, FSM states
// and the op decoder used by muldiv_unit.
package riscv_pkg;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_DIV    = 4'd4,
    MD_DIVU   = 4'd5,
    MD_REM    = 4'd6,
    MD_REMU   = 4'd7,
    MD_MULW   = 4'd8,
    MD_DIVW   = 4'd9,
    MD_DIVUW  = 4'd10,
    MD_REMW   = 4'd11,
    MD_REMUW  = 4'd12
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  typedef struct packed {
    logic legal;
    logic mul;
    logic hi;
    logic sgn_a;
    logic sgn_b;
    logic rem;
    logic word;
  } md_dec_t;

  function automatic logic is_word_op(md_op_t op);
    return op inside {MD_MULW, MD_DIVW, MD_DIVUW,
                      MD_REMW, MD_REMUW};
  endfunction

  function automatic md_dec_t md_decode(md_op_t op);
    md_dec_t d;
    d = '0;
    d.legal = 1'b1;
    d.word = is_word_op(op);
    case (op)
      MD_MUL, MD_MULW: d.mul = 1'b1;
      MD_MULH: begin
        d.mul = 1'b1;
        d.hi = 1'b1;
        d.sgn_a = 1'b1;
        d.sgn_b = 1'b1;
      end
      MD_MULHSU: begin
        d.mul = 1'b1;
        d.hi = 1'b1;
        d.sgn_a = 1'b1;
      end
      MD_MULHU: begin
        d.mul = 1'b1;
        d.hi = 1'b1;
      end
      MD_DIV, MD_DIVW: begin
        d.sgn_a = 1'b1;
        d.sgn_b = 1'b1;
      end
      MD_DIVU, MD_DIVUW: d.rem = 1'b0;
      MD_REM, MD_REMW: begin
        d.rem = 1'b1;
        d.sgn_a = 1'b1;
        d.sgn_b = 1'b1;
      end
      MD_REMU, MD_REMUW: d.rem = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply or restoring divide on a
// {hi, lo} accumulator pair.
module muldiv_iter_core #(
  parameter int XLEN = 64
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rtmp;
  logic [XLEN:0] diff;

  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]}
        + (acc[0] ? {1'b0, opnd} : '0);
    rtmp = acc[2*XLEN-1:XLEN-1];
    diff = rtmp - {1'b0, opnd};
    acc_nxt = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      // borrow out means the trial subtract failed: restore
      if (diff[XLEN])
        acc_nxt = {rtmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit with valid/ready on both sides.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  md_op_t          op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam int WSH = XLEN - 32;
  localparam bit W64 = (XLEN == 64);

  md_state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, init_acc, prod_it;
  logic [XLEN-1:0]   opnd, opnd_init, res;
  logic mul_q, hi_q, rem_q, word_q;
  logic negq_q, negr_q, spec_q;

  md_dec_t dec;
  logic word, sa, sb, div0, ovf, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
  logic [XLEN-1:0] min_val, dvd, spec_res, fin_res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  function automatic logic [XLEN-1:0] fix_mul(
    input logic [2*XLEN-1:0] p,
    input logic neg,
    input logic hi,
    input logic wd
  );
    logic [2*XLEN-1:0] ps;
    ps = neg ? -p : p;
    if (wd) return sext32(ps[31:0]);
    return hi ? ps[2*XLEN-1:XLEN] : ps[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] fix_div(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic negq,
    input logic negr,
    input logic rm,
    input logic wd
  );
    logic [XLEN-1:0] v;
    v = rm ? (negr ? -r : r) : (negq ? -q : q);
    return wd ? sext32(v[31:0]) : v;
  endfunction

  always_comb begin
    dec = md_decode(op_i);
    word = dec.word & W64;
    a_ext = op_a_i;
    b_ext = op_b_i;
    if (word) begin
      a_ext = dec.sgn_a ? sext32(op_a_i[31:0])
                        : XLEN'(op_a_i[31:0]);
      b_ext = dec.sgn_b ? sext32(op_b_i[31:0])
                        : XLEN'(op_b_i[31:0]);
    end
    sa = dec.sgn_a & a_ext[XLEN-1];
    sb = dec.sgn_b & b_ext[XLEN-1];
    mag_a = sa ? -a_ext : a_ext;
    mag_b = sb ? -b_ext : b_ext;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (word) min_val = sext32(32'h8000_0000);
    div0 = !dec.mul && (b_ext == '0);
    ovf = !dec.mul && dec.sgn_a && (&b_ext)
        && (a_ext == min_val);
    special = div0 | ovf;
    dvd = word ? sext32(op_a_i[31:0]) : op_a_i;
    if (div0)
      spec_res = dec.rem ? dvd : '1;
    else
      spec_res = dec.rem ? '0 : dvd;
    opnd_init = dec.mul ? mag_a : mag_b;
    // word divides pre-align the dividend so 32 steps consume it
    if (dec.mul)
      init_acc = {{XLEN{1'b0}}, mag_b};
    else
      init_acc = {{XLEN{1'b0}},
                  word ? (mag_a << WSH) : mag_a};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag_a}
              * {{XLEN{1'b0}}, mag_b};
    fast_res = fix_mul(fast_prod, sa ^ sb, dec.hi, word);
  end
`endif

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .is_div (!mul_q),
    .acc    (acc),
    .opnd   (opnd),
    .acc_nxt(acc_nxt)
  );

  always_comb begin
    prod_it = word_q ? (acc_nxt >> WSH) : acc_nxt;
    if (mul_q)
      fin_res = fix_mul(prod_it, negq_q, hi_q, word_q);
    else
      fin_res = fix_div(acc_nxt[XLEN-1:0],
                        acc_nxt[2*XLEN-1:XLEN],
                        negq_q, negr_q, rem_q, word_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !flush_i) begin
          accept = 1'b1;
          state_nxt = BUSY;
          if (!dec.legal || (special && EARLY_SPECIAL))
            state_nxt = DONE;
`ifdef MULDIV_FAST_MUL_EN
          if (dec.legal && dec.mul)
            state_nxt = DONE;
`endif
        end
      end
      BUSY: begin
        if (flush_i)
          state_nxt = IDLE;
        else if (cnt == '0)
          state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (flush_i || ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      res <= '0;
      mul_q <= 1'b0;
      hi_q <= 1'b0;
      rem_q <= 1'b0;
      word_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      spec_q <= 1'b0;
    end else if (accept) begin
      cnt <= word ? CW'(31) : CW'(XLEN-1);
      acc <= init_acc;
      opnd <= opnd_init;
      mul_q <= dec.mul;
      hi_q <= dec.hi;
      rem_q <= dec.rem;
      word_q <= word;
      negq_q <= sa ^ sb;
      negr_q <= sa;
      spec_q <= dec.legal & special;
      res <= '0;
      if (dec.legal && special) res <= spec_res;
`ifdef MULDIV_FAST_MUL_EN
      if (dec.legal && dec.mul) res <= fast_res;
`endif
    end else if (state == BUSY && !flush_i) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == '0 && !spec_q) res <= fin_res;
    end
  end

  assign result_o = res;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus handshake/flush/reset sequences
// for muldiv_unit at XLEN=64.
module tb_muldiv_unit;
  import riscv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 1;
  localparam int LMW = 1;
`else
  localparam int LM = 65;
  localparam int LMW = 33;
`endif

  typedef struct {
    md_op_t      op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  md_op_t      op = MD_MUL;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ready_out;
  logic        valid_out;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(
    .XLEN(64),
    .EARLY_SPECIAL(1'b1)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .valid_i (valid_in),
    .ready_o (ready_out),
    .op_i    (op),
    .op_a_i  (a),
    .op_b_i  (b),
    .valid_o (valid_out),
    .ready_i (ready_in),
    .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input md_op_t o,
                       input logic [63:0] x,
                       input logic [63:0] y);
    op = o;
    a = x;
    b = y;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
  endtask

  vec_t vq[$];
  int lat;
  logic seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vq.push_back('{MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                   64'hFFFF_FFFF_FFFF_FFEB, LM});
    vq.push_back('{MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                   64'd1, LM});
    vq.push_back('{MD_MULH, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LM});
    vq.push_back('{MD_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFF, LM});
    vq.push_back('{MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFE, LM});
    vq.push_back('{MD_MULH, 64'h8000_0000_0000_0000,
                   64'h8000_0000_0000_0000,
                   64'h4000_0000_0000_0000, LM});
    vq.push_back('{MD_MULW, 64'h7FFF_FFFF, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFE, LMW});
    vq.push_back('{MD_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                   64'hFFFF_FFFF_FFFF_FFFA, 65});
    vq.push_back('{MD_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                   64'hFFFF_FFFF_FFFF_FFFE, 65});
    vq.push_back('{MD_DIVU, 64'd100, 64'd7, 64'd14, 65});
    vq.push_back('{MD_REMU, 64'd100, 64'd7, 64'd2, 65});
    vq.push_back('{MD_DIVW, 64'h1_0000_0010, 64'd4,
                   64'd4, 33});
    vq.push_back('{MD_DIVUW, 64'hFFFF_FFFF, 64'd1,
                   64'hFFFF_FFFF_FFFF_FFFF, 33});
    vq.push_back('{MD_REMW, 64'hFFFF_FFF9, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFF, 33});
    vq.push_back('{MD_REMUW, 64'h8000_0005, 64'h10,
                   64'd5, 33});
    vq.push_back('{MD_DIVU, 64'd5, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1});
    vq.push_back('{MD_REM, 64'd5, 64'd0, 64'd5, 1});
    vq.push_back('{MD_DIV, 64'h8000_0000_0000_0000,
                   64'hFFFF_FFFF_FFFF_FFFF,
                   64'h8000_0000_0000_0000, 1});
    vq.push_back('{MD_REM, 64'h8000_0000_0000_0000,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
    vq.push_back('{MD_DIVW, 64'h8000_0000, 64'hFFFF_FFFF,
                   64'hFFFF_FFFF_8000_0000, 1});
    vq.push_back('{MD_REMUW, 64'h8000_0001, 64'd0,
                   64'hFFFF_FFFF_8000_0001, 1});
    vq.push_back('{md_op_t'(4'd13), 64'd9, 64'd3, 64'd0, 1});

    repeat (3) @(posedge clk);
    #1;
    check("reset ready_o", 64'(ready_out), 64'd1);
    check("reset valid_o", 64'(valid_out), 64'd0);
    check("reset result_o", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b);
      wait_valid(lat);
      check($sformatf("vec%0d result", i), result, vq[i].exp);
      check($sformatf("vec%0d latency", i),
            64'(lat), 64'(vq[i].lat));
      take();
    end

    // backpressure in DONE
    issue(MD_DIVU, 64'd100, 64'd7);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d valid_o", c), 64'(valid_out), 64'd1);
      check($sformatf("bp%0d result", c), result, 64'd14);
      check($sformatf("bp%0d ready_o", c), 64'(ready_out), 64'd0);
      @(posedge clk);
      #1;
    end
    take();
    check("bp after valid_o", 64'(valid_out), 64'd0);
    check("bp after ready_o", 64'(ready_out), 64'd1);

    // flush at BUSY cycle 20
    issue(MD_DIVU, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    check("flush busy pre ready_o", 64'(ready_out), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy valid_o", 64'(valid_out), 64'd0);
    check("flush busy ready_o", 64'(ready_out), 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      seen |= valid_out;
    end
    check("flush busy no result", 64'(seen), 64'd0);
    issue(MD_DIVU, 64'd100, 64'd7);
    wait_valid(lat);
    check("post flush result", result, 64'd14);
    check("post flush latency", 64'(lat), 64'd65);
    take();

    // flush in IDLE blocks the accept
    op = MD_DIVU;
    a = 64'd5;
    b = 64'd0;
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush = 1'b0;
    check("flush idle valid_o", 64'(valid_out), 64'd0);
    check("flush idle ready_o", 64'(ready_out), 64'd1);

    // flush in DONE wins over a stalled consumer
    issue(MD_DIVU, 64'd5, 64'd0);
    check("done pre flush valid_o", 64'(valid_out), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush done valid_o", 64'(valid_out), 64'd0);
    check("flush done ready_o", 64'(ready_out), 64'd1);

    // async reset mid-BUSY
    issue(MD_DIVU, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid valid_o", 64'(valid_out), 64'd0);
    check("rst mid ready_o", 64'(ready_out), 64'd1);
    check("rst mid result_o", result, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(MD_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    wait_valid(lat);
    check("post rst result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    check("post rst latency", 64'(lat), 64'd65);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
